// File: rtl/event_watchdog_if.sv
// rtl/event_watchdog_if.sv - control, monitored-value and status bundle for event_watchdog
interface event_watchdog_if #(
  parameter int NUM_CH = 4,
  parameter int TMO_W  = 22,
  parameter int VAL_W  = 12
);
  logic [NUM_CH-1:0]       arm;
  logic [NUM_CH-1:0]       mode;
  logic [TMO_W-1:0]        tmo_val;
  logic [NUM_CH-1:0]       evt;
  logic [NUM_CH*VAL_W-1:0] val;
  logic [NUM_CH*VAL_W-1:0] tgt;
  logic [NUM_CH-1:0]       clr;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       tmo;
  logic                    any_tmo;

  modport master (
    output arm, mode, tmo_val, evt, val, tgt, clr,
    input  busy, done, tmo, any_tmo
  );

  modport slave (
    input  arm, mode, tmo_val, evt, val, tgt, clr,
    output busy, done, tmo, any_tmo
  );
endinterface

// File: rtl/event_watchdog.sv
// rtl/event_watchdog.sv - per-channel watchdog: sticky pass on event/convergence, sticky fail on timeout
// Converge mode exists only when WDOG_CONVERGE_EN is defined; otherwise every channel is event mode.
module event_watchdog #(
  parameter int NUM_CH = 4,
  parameter int TMO_W  = 22,
  parameter int VAL_W  = 12,
  parameter int TOL    = 16,
  parameter int SETTLE = 8
) (
  input  logic            clk,
  input  logic            rst,
  event_watchdog_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS, S_FAIL} state_t;

  state_t            st_q  [NUM_CH];
  state_t            st_d  [NUM_CH];
  logic [TMO_W-1:0]  cnt_q [NUM_CH];
  logic [TMO_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] evt_prev;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] pass;
  logic [NUM_CH-1:0] fail_d;
  logic [NUM_CH-1:0] busy_v;
  logic [NUM_CH-1:0] done_v;
  logic [NUM_CH-1:0] tmo_v;
  logic              any_tmo_q;

  // evt_prev samples every cycle, so a rise seen in the arm cycle is consumed before WAIT
  assign rise = bus.evt & ~evt_prev;

`ifdef WDOG_CONVERGE_EN
  localparam logic [7:0] SETTLE_V = 8'(SETTLE);

  logic [7:0]        settle_q  [NUM_CH];
  logic [7:0]        settle_d  [NUM_CH];
  logic [7:0]        settle_nx [NUM_CH];
  logic [VAL_W:0]    diff      [NUM_CH];
  logic [VAL_W:0]    mag       [NUM_CH];
  logic              in_tol    [NUM_CH];
  logic [NUM_CH-1:0] mode_q;
  logic [NUM_CH-1:0] mode_d;

  // One extra bit keeps val - tgt exact across the full signed range
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      diff[i]      = {bus.val[i*VAL_W+VAL_W-1], bus.val[i*VAL_W +: VAL_W]}
                   - {bus.tgt[i*VAL_W+VAL_W-1], bus.tgt[i*VAL_W +: VAL_W]};
      mag[i]       = diff[i][VAL_W] ? -diff[i] : diff[i];
      in_tol[i]    = 32'(mag[i]) <= TOL;
      settle_nx[i] = !in_tol[i] ? 8'd0
                   : (settle_q[i] == SETTLE_V) ? SETTLE_V
                   : settle_q[i] + 8'd1;
      pass[i]      = mode_q[i] ? (settle_nx[i] == SETTLE_V) : rise[i];
    end
  end
`else
  logic unused_cfg;

  assign pass       = rise;
  assign unused_cfg = ^{bus.mode, bus.val, bus.tgt} ^ (TOL > 0) ^ (SETTLE > 0) ^ (VAL_W > 0);
`endif

  always_comb begin
`ifdef WDOG_CONVERGE_EN
    mode_d = mode_q;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
`ifdef WDOG_CONVERGE_EN
      settle_d[i] = settle_q[i];
`endif
      if (bus.arm[i]) begin
        st_d[i]  = S_WAIT;
        cnt_d[i] = bus.tmo_val;
`ifdef WDOG_CONVERGE_EN
        settle_d[i] = '0;
        mode_d[i]   = bus.mode[i];
`endif
      end else begin
        case (st_q[i])
          S_WAIT: begin
`ifdef WDOG_CONVERGE_EN
            settle_d[i] = settle_nx[i];
`endif
            // pass is checked before the expiry so a same-cycle tie passes
            if (pass[i]) begin
              st_d[i] = S_PASS;
            end else if (cnt_q[i] == '0) begin
              st_d[i] = S_FAIL;
            end else begin
              cnt_d[i] = cnt_q[i] - TMO_W'(1);
            end
          end
          S_PASS, S_FAIL: begin
            if (bus.clr[i]) begin
              st_d[i] = S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      fail_d[i] = (st_d[i] == S_FAIL);
      busy_v[i] = (st_q[i] == S_WAIT);
      done_v[i] = (st_q[i] == S_PASS);
      tmo_v[i]  = (st_q[i] == S_FAIL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= '0;
`ifdef WDOG_CONVERGE_EN
        settle_q[i] <= '0;
`endif
      end
      evt_prev  <= '0;
      any_tmo_q <= 1'b0;
`ifdef WDOG_CONVERGE_EN
      mode_q <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
`ifdef WDOG_CONVERGE_EN
        settle_q[i] <= settle_d[i];
`endif
      end
      evt_prev  <= bus.evt;
      // built from next state so it lines up with tmo
      any_tmo_q <= |fail_d;
`ifdef WDOG_CONVERGE_EN
      mode_q <= mode_d;
`endif
    end
  end

  assign bus.busy    = busy_v;
  assign bus.done    = done_v;
  assign bus.tmo     = tmo_v;
  assign bus.any_tmo = any_tmo_q;
endmodule
